// File: rtl/vga_pkg.sv
// vga_pkg: shared video definitions.
//   mode_t    : per-frame pattern selector encoding
//   BAR_RGB   : 8-entry colour-bar table, {R,G,B}, left to right
//   cnt_width : counter width needed to hold 0..period-1
package vga_pkg;

   typedef enum logic [1:0] {
      MODE_GRAD  = 2'd0,
      MODE_BARS  = 2'd1,
      MODE_CHECK = 2'd2,
      MODE_SOLID = 2'd3
   } mode_t;

   localparam logic [23:0] BAR_RGB [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   function automatic int unsigned cnt_width(input int unsigned period);
      return (period < 2) ? 1 : $clog2(period);
   endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running VGA raster counters and sync/active decode.
// Line and frame order are front porch, sync, back porch, active.
// Ports:
//   i_clk, i_rst : pixel clock, asynchronous active-high reset
//   o_hcnt       : pixel counter 0..HPERIOD-1
//   o_vcnt       : line counter 0..VPERIOD-1
//   o_hsync      : 1 while inside the horizontal sync pulse (logical)
//   o_vsync      : 1 while inside the vertical sync pulse (logical)
//   o_active     : 1 inside the active picture
//   o_eol        : last pixel of a line
//   o_eof        : last pixel of a frame
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned HACTIVE = 640,
   parameter int unsigned HFRONT  = 16,
   parameter int unsigned HWIDTH  = 96,
   parameter int unsigned HBACK   = 48,
   parameter int unsigned VACTIVE = 480,
   parameter int unsigned VFRONT  = 10,
   parameter int unsigned VWIDTH  = 2,
   parameter int unsigned VBACK   = 33,
   localparam int unsigned HPERIOD = HACTIVE + HFRONT + HWIDTH + HBACK,
   localparam int unsigned VPERIOD = VACTIVE + VFRONT + VWIDTH + VBACK,
   localparam int unsigned HW      = cnt_width(HPERIOD),
   localparam int unsigned VW      = cnt_width(VPERIOD)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   output logic [HW-1:0] o_hcnt,
   output logic [VW-1:0] o_vcnt,
   output logic          o_hsync,
   output logic          o_vsync,
   output logic          o_active,
   output logic          o_eol,
   output logic          o_eof
);

   localparam int unsigned HBLANK = HFRONT + HWIDTH + HBACK;
   localparam int unsigned VBLANK = VFRONT + VWIDTH + VBACK;

   logic [HW-1:0] r_hcnt;
   logic [VW-1:0] r_vcnt;
   logic          w_eol;
   logic          w_eof;

   assign w_eol = (r_hcnt == HW'(HPERIOD - 1));
   assign w_eof = w_eol && (r_vcnt == VW'(VPERIOD - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (w_eol) begin
         r_hcnt <= '0;
         r_vcnt <= w_eof ? '0 : r_vcnt + 1'b1;
      end else begin
         r_hcnt <= r_hcnt + 1'b1;
      end
   end

   assign o_hcnt   = r_hcnt;
   assign o_vcnt   = r_vcnt;
   assign o_hsync  = (r_hcnt >= HW'(HFRONT)) && (r_hcnt < HW'(HFRONT + HWIDTH));
   assign o_vsync  = (r_vcnt >= VW'(VFRONT)) && (r_vcnt < VW'(VFRONT + VWIDTH));
   assign o_active = (r_hcnt >= HW'(HBLANK)) && (r_vcnt >= VW'(VBLANK));
   assign o_eol    = w_eol;
   assign o_eof    = w_eof;

endmodule

// File: rtl/pattern_gen_multi.sv
// pattern_gen_multi: VGA test-pattern generator with four per-frame patterns
// (gradient bands, colour bars, checkerboard, solid colour). All outputs are
// registered one cycle after the raster position that produces them.
// Ports:
//   CLK, RST     : pixel clock, asynchronous active-high reset
//   MODE         : pattern select, latched at end of frame
//   SOLID_RGB    : {R,G,B} for solid mode, latched at end of frame
//   VGA_R/G/B    : pixel colour, 0 outside the active picture
//   VGA_HS/VS    : sync outputs, asserted level SYNC_POL
//   VGA_DE       : data enable
//   FRAME_START  : one-cycle pulse aligned with the outputs of raster (0,0)
module pattern_gen_multi
   import vga_pkg::*;
#(
   parameter int unsigned HACTIVE    = 640,
   parameter int unsigned HFRONT     = 16,
   parameter int unsigned HWIDTH     = 96,
   parameter int unsigned HBACK      = 48,
   parameter int unsigned VACTIVE    = 480,
   parameter int unsigned VFRONT     = 10,
   parameter int unsigned VWIDTH     = 2,
   parameter int unsigned VBACK      = 33,
   parameter int unsigned HSIZE      = 64,
   parameter int unsigned VBANDS     = 4,
   parameter int unsigned CHECK_LOG2 = 5,
   parameter logic        SYNC_POL   = 1'b0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [1:0]  MODE,
   input  logic [23:0] SOLID_RGB,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_DE,
   output logic        FRAME_START
);

   localparam int unsigned HBLANK = HFRONT + HWIDTH + HBACK;
   localparam int unsigned VBLANK = VFRONT + VWIDTH + VBACK;
   localparam int unsigned HW     = cnt_width(HACTIVE + HBLANK);
   localparam int unsigned VW     = cnt_width(VACTIVE + VBLANK);
   localparam int unsigned HLOG   = $clog2(HSIZE);
   localparam int unsigned BARW   = HACTIVE / 8;
   localparam int unsigned LPB    = VACTIVE / VBANDS;
   localparam int unsigned BARPW  = cnt_width(BARW);
   localparam int unsigned LIBW   = cnt_width(LPB);
   localparam int unsigned BANDW  = (VBANDS > 4) ? $clog2(VBANDS) : 2;

   logic [HW-1:0]    w_hcnt;
   logic [VW-1:0]    w_vcnt;
   logic             w_hs, w_vs, w_active, w_eol, w_eof;

   mode_t            r_mode;
   logic [23:0]      r_solid;
   logic [2:0]       r_bar;
   logic [BARPW-1:0] r_barpix;
   logic [BANDW-1:0] r_band;
   logic [LIBW-1:0]  r_lib;

   logic [HLOG-1:0]  w_xm;
   logic             w_xbit, w_ybit;
   logic [7:0]       w_lvl;
   logic [23:0]      w_rgb;

   logic [23:0]      r_rgb;
   logic             r_hs, r_vs, r_de, r_fs;

   vga_timing #(
      .HACTIVE (HACTIVE),
      .HFRONT  (HFRONT),
      .HWIDTH  (HWIDTH),
      .HBACK   (HBACK),
      .VACTIVE (VACTIVE),
      .VFRONT  (VFRONT),
      .VWIDTH  (VWIDTH),
      .VBACK   (VBACK)
   ) u_timing (
      .i_clk    (CLK),
      .i_rst    (RST),
      .o_hcnt   (w_hcnt),
      .o_vcnt   (w_vcnt),
      .o_hsync  (w_hs),
      .o_vsync  (w_vs),
      .o_active (w_active),
      .o_eol    (w_eol),
      .o_eof    (w_eof)
   );

   // Controls change only on the last pixel of a frame, so a frame never tears.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_mode  <= MODE_GRAD;
         r_solid <= '0;
      end else if (w_eof) begin
         r_mode  <= mode_t'(MODE);
         r_solid <= SOLID_RGB;
      end
   end

   // Bar index tracks x without a divider: cleared on the pixel before x=0 so
   // it already reads 0 while x=0 is on the counters.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_bar    <= '0;
         r_barpix <= '0;
      end else if (w_hcnt == HW'(HBLANK - 1)) begin
         r_bar    <= '0;
         r_barpix <= '0;
      end else if (w_active) begin
         if (r_barpix == BARPW'(BARW - 1)) begin
            r_barpix <= '0;
            r_bar    <= r_bar + 1'b1;
         end else begin
            r_barpix <= r_barpix + 1'b1;
         end
      end
   end

   // Band index tracks y the same way, stepping at the end of each line so the
   // value is valid for the whole of the following line.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_band <= '0;
         r_lib  <= '0;
      end else if (w_eol) begin
         if (w_vcnt == VW'(VBLANK - 1)) begin
            r_band <= '0;
            r_lib  <= '0;
         end else if (w_vcnt >= VW'(VBLANK)) begin
            if (r_lib == LIBW'(LPB - 1)) begin
               r_lib  <= '0;
               r_band <= r_band + 1'b1;
            end else begin
               r_lib <= r_lib + 1'b1;
            end
         end
      end
   end

   assign w_xm   = HLOG'(w_hcnt - HW'(HBLANK));
   assign w_xbit = 1'((w_hcnt - HW'(HBLANK)) >> CHECK_LOG2);
   assign w_ybit = 1'((w_vcnt - VW'(VBLANK)) >> CHECK_LOG2);
   assign w_lvl  = 8'(w_xm) << (8 - HLOG);

   always_comb begin
      w_rgb = '0;
      if (w_active) begin
         case (r_mode)
            MODE_GRAD: begin
               case (r_band[1:0])
                  2'd0:    w_rgb = {w_lvl, w_lvl, w_lvl};
                  2'd1:    w_rgb = {w_lvl, 8'h00, 8'h00};
                  2'd2:    w_rgb = {8'h00, w_lvl, 8'h00};
                  default: w_rgb = {8'h00, 8'h00, w_lvl};
               endcase
            end
            MODE_BARS:  w_rgb = BAR_RGB[r_bar];
            MODE_CHECK: w_rgb = (w_xbit ^ w_ybit) ? '1 : '0;
            default:    w_rgb = r_solid;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_rgb <= '0;
         r_de  <= 1'b0;
         r_fs  <= 1'b0;
         r_hs  <= ~SYNC_POL;
         r_vs  <= ~SYNC_POL;
      end else begin
         r_rgb <= w_rgb;
         r_de  <= w_active;
         r_fs  <= (w_hcnt == '0) && (w_vcnt == '0);
         r_hs  <= w_hs ? SYNC_POL : ~SYNC_POL;
         r_vs  <= w_vs ? SYNC_POL : ~SYNC_POL;
      end
   end

   assign VGA_R       = r_rgb[23:16];
   assign VGA_G       = r_rgb[15:8];
   assign VGA_B       = r_rgb[7:0];
   assign VGA_HS      = r_hs;
   assign VGA_VS      = r_vs;
   assign VGA_DE      = r_de;
   assign FRAME_START = r_fs;

endmodule

// File: tb/tb_pattern_gen_multi.sv
// Scoreboard bench for pattern_gen_multi on a reduced raster (72x20 frame).
module tb_pattern_gen_multi;

   localparam int HA = 64, HF = 2, HWD = 4, HB = 2;
   localparam int VA = 16, VF = 1, VWD = 2, VB = 1;
   localparam int HSZ = 16, NB = 4, CL = 2;
   localparam logic POL = 1'b0;
   localparam int HBL = HF + HWD + HB;
   localparam int VBL = VF + VWD + VB;
   localparam int HP  = HA + HBL;
   localparam int VP  = VA + VBL;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [1:0]  MODE = 2'd0;
   logic [23:0] SOLID_RGB = 24'h0;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic        VGA_HS, VGA_VS, VGA_DE, FRAME_START;

   pattern_gen_multi #(
      .HACTIVE(HA), .HFRONT(HF), .HWIDTH(HWD), .HBACK(HB),
      .VACTIVE(VA), .VFRONT(VF), .VWIDTH(VWD), .VBACK(VB),
      .HSIZE(HSZ), .VBANDS(NB), .CHECK_LOG2(CL), .SYNC_POL(POL)
   ) dut (
      .CLK(CLK), .RST(RST), .MODE(MODE), .SOLID_RGB(SOLID_RGB),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE),
      .FRAME_START(FRAME_START)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [27:0] val;
      int          h;
      int          v;
      logic [1:0]  m;
   } exp_t;

   typedef struct {
      logic [1:0]  m;
      int          x;
      int          y;
      logic [23:0] rgb;
   } probe_t;

   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   exp_t   sbq[$];
   probe_t probes[13];
   int     hits[13];
   int     n_tests = 0;
   int     n_fail  = 0;
   bit     run = 1'b0;
   int     mh = 0, mv = 0;
   logic [1:0]  ml = 2'd0;
   logic [23:0] sl = 24'h0;

   // Expected {FRAME_START, DE, VS, HS, R, G, B} straight from raster position.
   function automatic logic [27:0] model(input int h, input int v,
                                         input logic [1:0] m, input logic [23:0] s);
      logic [23:0] rgb;
      logic [7:0]  l;
      logic        de, hs, vs, fs;
      int          x, y, band;
      rgb = 24'h0;
      de  = (h >= HBL) && (v >= VBL);
      x   = h - HBL;
      y   = v - VBL;
      if (de) begin
         case (m)
            2'd0: begin
               l    = 8'((x % HSZ) * (256 / HSZ));
               band = (y / (VA / NB)) % 4;
               case (band)
                  0:       rgb = {l, l, l};
                  1:       rgb = {l, 8'h00, 8'h00};
                  2:       rgb = {8'h00, l, 8'h00};
                  default: rgb = {8'h00, 8'h00, l};
               endcase
            end
            2'd1: rgb = bars[x / (HA / 8)];
            2'd2: rgb = (((x >> CL) ^ (y >> CL)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
            default: rgb = s;
         endcase
      end
      hs = (h >= HF && h < HF + HWD) ? POL : ~POL;
      vs = (v >= VF && v < VF + VWD) ? POL : ~POL;
      fs = (h == 0) && (v == 0);
      return {fs, de, vs, hs, rgb};
   endfunction

   function automatic logic [27:0] outs();
      return {FRAME_START, VGA_DE, VGA_VS, VGA_HS, VGA_R, VGA_G, VGA_B};
   endfunction

   task automatic check_reset(input string name);
      logic [27:0] want;
      want = {1'b0, 1'b0, ~POL, ~POL, 24'h0};
      n_tests++;
      if (outs() !== want) begin
         n_fail++;
         $display("FAIL %s got %h want %h", name, outs(), want);
      end
   endtask

   // Reference raster: pushes what the DUT must show after this edge.
   initial forever begin
      exp_t e;
      @(posedge CLK);
      if (RST) begin
         mh = 0; mv = 0; ml = 2'd0; sl = 24'h0;
      end else if (run) begin
         e.val = model(mh, mv, ml, sl);
         e.h = mh; e.v = mv; e.m = ml;
         sbq.push_back(e);
         if (mh == HP - 1 && mv == VP - 1) begin
            ml = MODE;
            sl = SOLID_RGB;
         end
         if (mh == HP - 1) begin
            mh = 0;
            mv = (mv == VP - 1) ? 0 : mv + 1;
         end else begin
            mh = mh + 1;
         end
      end
   end

   // Monitor: pops one expectation per presented output cycle.
   initial forever begin
      exp_t e;
      logic [27:0] act;
      @(negedge CLK);
      if (sbq.size() > 0) begin
         e   = sbq.pop_front();
         act = outs();
         n_tests++;
         if (act !== e.val) begin
            n_fail++;
            $display("FAIL out h=%0d v=%0d got %h want %h", e.h, e.v, act, e.val);
         end
         if (e.val[26]) begin
            for (int i = 0; i < 13; i++) begin
               if (probes[i].m == e.m && probes[i].x == e.h - HBL && probes[i].y == e.v - VBL) begin
                  hits[i]++;
                  n_tests++;
                  if (act[23:0] !== probes[i].rgb) begin
                     n_fail++;
                     $display("FAIL probe%0d m=%0d x=%0d y=%0d got %h want %h",
                              i, probes[i].m, probes[i].x, probes[i].y, act[23:0], probes[i].rgb);
                  end
               end
            end
         end
      end
   end

   initial begin
      probes[0]  = '{2'd0,  5,  0, 24'h505050};
      probes[1]  = '{2'd0, 20,  4, 24'h400000};
      probes[2]  = '{2'd0, 17,  8, 24'h001000};
      probes[3]  = '{2'd0, 15, 12, 24'h0000F0};
      probes[4]  = '{2'd1,  8,  3, 24'hFFFF00};
      probes[5]  = '{2'd1, 40,  1, 24'hFF0000};
      probes[6]  = '{2'd1, 63,  0, 24'h000000};
      probes[7]  = '{2'd1, 20,  0, 24'h00FFFF};
      probes[8]  = '{2'd2,  0,  0, 24'h000000};
      probes[9]  = '{2'd2,  4,  0, 24'hFFFFFF};
      probes[10] = '{2'd2,  4,  4, 24'h000000};
      probes[11] = '{2'd2,  0,  5, 24'hFFFFFF};
      probes[12] = '{2'd3,  0,  0, 24'h123456};
      for (int i = 0; i < 13; i++) hits[i] = 0;

      #1 RST = 1'b1;
      repeat (3) @(negedge CLK);
      #1 check_reset("rst_hold");
      @(negedge CLK);
      RST = 1'b0;
      run = 1'b1;

      // One frame is 1440 cycles; each switch lands mid-frame.
      repeat (700)  @(negedge CLK);
      MODE = 2'd1;
      repeat (1440) @(negedge CLK);
      MODE = 2'd2;
      repeat (1440) @(negedge CLK);
      MODE = 2'd3;
      SOLID_RGB = 24'h123456;
      repeat (2880) @(negedge CLK);

      // Asynchronous reset mid-frame, checked before any further clock edge.
      #2 RST = 1'b1;
      run = 1'b0;
      #1 check_reset("async_rst");
      sbq.delete();
      repeat (2) @(negedge CLK);
      #1 check_reset("async_rst_hold");
      @(negedge CLK);
      RST = 1'b0;
      run = 1'b1;
      repeat (1500) @(negedge CLK);
      run = 1'b0;
      repeat (3) @(negedge CLK);

      for (int i = 0; i < 13; i++) begin
         n_tests++;
         if (hits[i] < 1) begin
            n_fail++;
            $display("FAIL probe_hit%0d got %0d want >=1", i, hits[i]);
         end
      end
      n_tests++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d want 0", sbq.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
